// File: rtl/data_mem_port_pkg.sv
// Shared types and constants for the data memory port.
// Optional feature macro: DATA_MEM_MISALIGN_TRAP_EN.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Access size encodings (func3[1:0])
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam int unsigned BE_WIDTH = 8;

endpackage

// File: rtl/data_mem_port_if.sv
// Valid/ready bus between the data memory port and a 64-bit doubleword memory.
interface data_mem_port_if #(
  parameter int AddrSize = 64
) ();

  logic                mem_valid;
  logic                mem_we;
  logic [AddrSize-1:0] mem_addr;
  logic [7:0]          mem_be;
  logic [63:0]         mem_wdata;
  logic                mem_ready;
  logic [63:0]         mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/data_mem_port_lane_align.sv
// Byte-lane alignment: store enables/data shifted up to the addressed lane,
// read data shifted down to bit 0 and trimmed to the access size.
// DATA_MEM_MISALIGN_TRAP_EN enables the misalignment predicate; otherwise it is 0.
module lane_align
  import mem_port_pkg::*;
(
  input  logic [1:0]          size,
  input  logic [2:0]          off,
  input  logic [63:0]         store_value,
  output logic [BE_WIDTH-1:0] be,
  output logic [63:0]         wdata,
  output logic                misaligned,
  input  logic [1:0]          rd_size,
  input  logic [2:0]          rd_off,
  input  logic [63:0]         rd_data,
  output logic [63:0]         rd_aligned
);

  logic [BE_WIDTH-1:0] be_base;
  logic [63:0]         rd_mask;

  // Byte enable pattern for the size, shifted to the lane (upper lanes drop off)
  always_comb begin
    be_base = '0;
    case (size)
      SIZE_B:  be_base = 8'h01;
      SIZE_H:  be_base = 8'h03;
      SIZE_W:  be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    be = be_base << off;
  end

  assign wdata = store_value << {off, 3'b000};

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  logic [2:0] align_mask;

  // Offset must be a multiple of the access size
  always_comb begin
    align_mask = '0;
    case (size)
      SIZE_B:  align_mask = 3'b000;
      SIZE_H:  align_mask = 3'b001;
      SIZE_W:  align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    misaligned = (off & align_mask) != 3'b000;
  end
`else
  assign misaligned = 1'b0;
`endif

  // Read data moved down to bit 0 with bytes above the access size cleared
  always_comb begin
    rd_mask = '0;
    case (rd_size)
      SIZE_B:  rd_mask = 64'h0000_0000_0000_00FF;
      SIZE_H:  rd_mask = 64'h0000_0000_0000_FFFF;
      SIZE_W:  rd_mask = 64'h0000_0000_FFFF_FFFF;
      default: rd_mask = '1;
    endcase
    rd_aligned = (rd_data >> {rd_off, 3'b000}) & rd_mask;
  end

endmodule

// File: rtl/data_mem_port.sv
// Data memory port: latches a load/store/fetch request, runs one valid/ready
// transfer to the doubleword memory and returns LSB-aligned read data.
// DATA_MEM_MISALIGN_TRAP_EN: misaligned requests complete immediately with
// misaligned=1 and no memory transfer.
module data_mem_port
  import mem_port_pkg::*;
#(
  parameter int AddrSize = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                write,
  input  logic [1:0]          size,
  input  logic [AddrSize-1:0] addr,
  input  logic [63:0]         store_value,
  output logic [63:0]         rdata_o,
  output logic                done,
  output logic                busy,
  output logic                misaligned,
  data_mem_port_if.master     mem
);

  state_t state, state_next;

  logic [1:0]          req_size;
  logic [2:0]          req_off;
  logic                valid_q, we_q, done_q, busy_q, mis_q;
  logic [AddrSize-1:0] addr_q;
  logic [BE_WIDTH-1:0] be_q;
  logic [63:0]         wdata_q, rdata_q;

  logic [BE_WIDTH-1:0] align_be;
  logic [63:0]         align_wdata, rd_aligned;
  logic                align_mis;

  lane_align u_lane_align (
    .size        (size),
    .off         (addr[2:0]),
    .store_value (store_value),
    .be          (align_be),
    .wdata       (align_wdata),
    .misaligned  (align_mis),
    .rd_size     (req_size),
    .rd_off      (req_off),
    .rd_data     (mem.mem_rdata),
    .rd_aligned  (rd_aligned)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = align_mis ? RESP : REQ;
      REQ:     if (mem.mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so every output is a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      we_q     <= 1'b0;
      req_size <= '0;
      req_off  <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      done_q  <= (state_next == RESP);
      busy_q  <= (state_next != IDLE);
      valid_q <= (state_next == REQ);
      if (state == IDLE && start) begin
        we_q     <= write;
        req_size <= size;
        req_off  <= addr[2:0];
        addr_q   <= {addr[AddrSize-1:3], 3'b000};
        be_q     <= align_be;
        wdata_q  <= align_wdata;
        mis_q    <= align_mis;
      end else if (state == RESP) begin
        mis_q <= 1'b0;
      end
      if (state == REQ && mem.mem_ready && !we_q) rdata_q <= rd_aligned;
    end
  end

  assign rdata_o       = rdata_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign misaligned    = mis_q;
  assign mem.mem_valid = valid_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: directed scenarios plus randomized
// accesses against a byte-level memory model. Honours DATA_MEM_MISALIGN_TRAP_EN.
module tb_data_mem_port;

  localparam int AW = 64;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, write;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [63:0]   store_value, rdata_o;
  logic          done, busy, misaligned;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_rdata_o;
  logic [63:0] mem_model [logic [63:0]];

  data_mem_port_if #(.AddrSize(AW)) mif ();

  data_mem_port #(.AddrSize(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .write       (write),
    .size        (size),
    .addr        (addr),
    .store_value (store_value),
    .rdata_o     (rdata_o),
    .done        (done),
    .busy        (busy),
    .misaligned  (misaligned),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (byte-level) ----------------
  function automatic logic [7:0] model_be(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < (1 << sz); i++)
      if (int'(off) + i < 8) r[int'(off) + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] sv, input logic [2:0] off);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (int'(off) + i < 8) r[8*(int'(off)+i) +: 8] = sv[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_rdata(input logic [63:0] dw, input logic [1:0] sz,
                                              input logic [2:0] off);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < (1 << sz); j++)
      if (int'(off) + j < 8) r[8*j +: 8] = dw[8*(int'(off)+j) +: 8];
    return r;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [2:0] off);
    return TRAP && ((int'(off) % (1 << sz)) != 0);
  endfunction

  // ---------------- transaction driver (observes, does not judge) ----------------
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [63:0] a,
                         input logic [63:0] sv, input logic [63:0] rd, input int dly,
                         output int lat, output int vcyc, output logic [63:0] o_addr,
                         output logic [7:0] o_be, output logic [63:0] o_wdata,
                         output logic o_we, output logic o_mis);
    lat = -1; vcyc = 0; o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0; o_mis = 1'b0;
    @(negedge clk);
    start = 1'b1; write = w; size = sz; addr = a; store_value = sv;
    mif.mem_rdata = rd; mif.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; write = 1'($urandom); size = 2'($urandom);
    addr = {$urandom, $urandom}; store_value = {$urandom, $urandom};
    for (int c = 1; c <= 40; c++) begin
      if (mif.mem_valid) begin
        vcyc++;
        o_addr = mif.mem_addr; o_be = mif.mem_be; o_wdata = mif.mem_wdata; o_we = mif.mem_we;
      end
      if (done) begin
        lat = c; o_mis = misaligned;
        break;
      end
      mif.mem_ready = mif.mem_valid ? (vcyc > dly) : 1'($urandom);
      @(negedge clk);
    end
    mif.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; start = 1'b0; write = 1'b0; size = '0; addr = '0; store_value = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rdata_o = '0;
    @(negedge clk);
    checks++; if (rdata_o !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b expected 0", misaligned); end
    checks++; if (mif.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mif.mem_valid); end
    checks++; if (mif.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mif.mem_we); end
    checks++; if (mif.mem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mif.mem_addr); end
    checks++; if (mif.mem_be !== 8'h0) begin errors++; $display("FAIL reset_be: got %h expected 0", mif.mem_be); end
    checks++; if (mif.mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mif.mem_wdata); end
  endtask

  task automatic test_store_byte;
    int lat, vc; logic [63:0] oa, ow; logic [7:0] ob; logic owe, om;
    run_txn(1'b1, 2'd0, 64'h1003, 64'hAB, 64'h0, 0, lat, vc, oa, ob, ow, owe, om);
    checks++; if (oa !== 64'h1000) begin errors++; $display("FAIL sb_addr: got %h expected 1000", oa); end
    checks++; if (ob !== 8'h08) begin errors++; $display("FAIL sb_be: got %h expected 08", ob); end
    checks++; if (ow !== 64'h0000_0000_AB00_0000) begin errors++; $display("FAIL sb_wdata: got %h expected 00000000ab000000", ow); end
    checks++; if (owe !== 1'b1) begin errors++; $display("FAIL sb_we: got %b expected 1", owe); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sb_latency: got %0d expected 2", lat); end
    checks++; if (rdata_o !== exp_rdata_o) begin errors++; $display("FAIL sb_rdata_hold: got %h expected %h", rdata_o, exp_rdata_o); end
  endtask

  task automatic test_load_wait;
    int lat, vc; logic [63:0] oa, ow; logic [7:0] ob; logic owe, om;
    run_txn(1'b0, 2'd2, 64'h2004, 64'h0, 64'h1122_3344_5566_7788, 3, lat, vc, oa, ob, ow, owe, om);
    exp_rdata_o = 64'h1122_3344;
    checks++; if (vc !== 4) begin errors++; $display("FAIL lw_valid_cycles: got %0d expected 4", vc); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL lw_latency: got %0d expected 5", lat); end
    checks++; if (oa !== 64'h2000) begin errors++; $display("FAIL lw_addr: got %h expected 2000", oa); end
    checks++; if (ob !== 8'hF0) begin errors++; $display("FAIL lw_be: got %h expected f0", ob); end
    checks++; if (rdata_o !== exp_rdata_o) begin errors++; $display("FAIL lw_rdata: got %h expected %h", rdata_o, exp_rdata_o); end
  endtask

  task automatic test_load_store_hold;
    int lat, vc; logic [63:0] oa, ow, dw; logic [7:0] ob; logic owe, om;
    dw = {$urandom, $urandom};
    run_txn(1'b0, 2'd3, 64'h0, 64'h0, dw, 1, lat, vc, oa, ob, ow, owe, om);
    exp_rdata_o = dw;
    checks++; if (rdata_o !== exp_rdata_o) begin errors++; $display("FAIL ld_rdata: got %h expected %h", rdata_o, exp_rdata_o); end
    run_txn(1'b1, 2'd3, 64'h8, {$urandom, $urandom}, ~dw, 0, lat, vc, oa, ob, ow, owe, om);
    checks++; if (ob !== 8'hFF) begin errors++; $display("FAIL sd_be: got %h expected ff", ob); end
    checks++; if (rdata_o !== exp_rdata_o) begin errors++; $display("FAIL sd_rdata_hold: got %h expected %h", rdata_o, exp_rdata_o); end
  endtask

  task automatic test_misalign;
    int lat, vc; logic [63:0] oa, ow, dw; logic [7:0] ob; logic owe, om;
    dw = {$urandom, $urandom};
    run_txn(1'b0, 2'd1, 64'h1, 64'h0, dw, 0, lat, vc, oa, ob, ow, owe, om);
    if (TRAP) begin
      checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency: got %0d expected 1", lat); end
      checks++; if (vc !== 0) begin errors++; $display("FAIL mis_valid_cycles: got %0d expected 0", vc); end
      checks++; if (om !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", om); end
    end else begin
      exp_rdata_o = model_rdata(dw, 2'd1, 3'd1);
      checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency: got %0d expected 2", lat); end
      checks++; if (ob !== 8'h06) begin errors++; $display("FAIL mis_be: got %h expected 06", ob); end
      checks++; if (om !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b expected 0", om); end
    end
    checks++; if (rdata_o !== exp_rdata_o) begin errors++; $display("FAIL mis_rdata: got %h expected %h", rdata_o, exp_rdata_o); end
  endtask

  task automatic test_reset_midtransfer;
    int lat, vc, nd; logic [63:0] oa, ow, dw; logic [7:0] ob; logic owe, om;
    @(negedge clk);
    start = 1'b1; write = 1'b0; size = 2'd3; addr = 64'h18; mif.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (mif.mem_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_valid_before: got %b expected 1", mif.mem_valid); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (mif.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", mif.mem_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    nd = 0;
    @(negedge clk);
    if (done) nd++;
    reset = 1'b0;
    exp_rdata_o = '0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", nd); end
    dw = {$urandom, $urandom};
    run_txn(1'b0, 2'd2, 64'h28, 64'h0, dw, 1, lat, vc, oa, ob, ow, owe, om);
    exp_rdata_o = model_rdata(dw, 2'd2, 3'd0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_mid_next_latency: got %0d expected 3", lat); end
    checks++; if (rdata_o !== exp_rdata_o) begin errors++; $display("FAIL rst_mid_next_rdata: got %h expected %h", rdata_o, exp_rdata_o); end
  endtask

  task automatic test_start_ignored;
    int nd, vc; logic [63:0] cap, dw;
    dw = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b1; write = 1'b0; size = 2'd3; addr = 64'h40;
    mif.mem_rdata = dw; mif.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nd = 0; vc = 0; cap = '0;
    for (int c = 1; c <= 12; c++) begin
      if (mif.mem_valid) begin vc++; cap = mif.mem_addr; end
      if (done) nd++;
      start = busy;
      addr = 64'h80;
      mif.mem_ready = mif.mem_valid && (vc > 2);
      @(negedge clk);
    end
    start = 1'b0; mif.mem_ready = 1'b0;
    exp_rdata_o = dw;
    checks++; if (nd !== 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", nd); end
    checks++; if (vc !== 3) begin errors++; $display("FAIL ign_valid_cycles: got %0d expected 3", vc); end
    checks++; if (cap !== 64'h40) begin errors++; $display("FAIL ign_addr_stable: got %h expected 40", cap); end
    checks++; if (rdata_o !== exp_rdata_o) begin errors++; $display("FAIL ign_rdata: got %h expected %h", rdata_o, exp_rdata_o); end
  endtask

  task automatic test_random;
    int lat, vc, dly; logic [63:0] oa, ow, a, sv, rd, key, line; logic [7:0] ob, eb;
    logic owe, om, w; logic [1:0] sz; logic [2:0] off; bit mis;
    for (int n = 0; n < 60; n++) begin
      a = 64'($urandom_range(0, 63)); sz = 2'($urandom); w = 1'($urandom);
      sv = {$urandom, $urandom}; dly = $urandom_range(0, 3);
      off = a[2:0]; key = a >> 3;
      if (!mem_model.exists(key)) mem_model[key] = {$urandom, $urandom};
      rd = mem_model[key];
      mis = model_mis(sz, off);
      run_txn(w, sz, a, sv, rd, dly, lat, vc, oa, ob, ow, owe, om);
      if (mis) begin
        checks++; if (lat !== 1) begin errors++; $display("FAIL rnd%0d_trap_latency: got %0d expected 1", n, lat); end
        checks++; if (vc !== 0) begin errors++; $display("FAIL rnd%0d_trap_valid: got %0d expected 0", n, vc); end
        checks++; if (om !== 1'b1) begin errors++; $display("FAIL rnd%0d_trap_flag: got %b expected 1", n, om); end
      end else begin
        eb = model_be(sz, off);
        checks++; if (lat !== dly + 2) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, dly + 2); end
        checks++; if (vc !== dly + 1) begin errors++; $display("FAIL rnd%0d_valid: got %0d expected %0d", n, vc, dly + 1); end
        checks++; if (oa !== (key << 3)) begin errors++; $display("FAIL rnd%0d_addr: got %h expected %h", n, oa, key << 3); end
        checks++; if (ob !== eb) begin errors++; $display("FAIL rnd%0d_be: got %h expected %h", n, ob, eb); end
        checks++; if (ow !== model_wdata(sv, off)) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, ow, model_wdata(sv, off)); end
        checks++; if (owe !== w) begin errors++; $display("FAIL rnd%0d_we: got %b expected %b", n, owe, w); end
        checks++; if (om !== 1'b0) begin errors++; $display("FAIL rnd%0d_flag: got %b expected 0", n, om); end
        if (w) begin
          line = mem_model[key];
          for (int b = 0; b < 8; b++)
            if (eb[b]) line[8*b +: 8] = model_wdata(sv, off) >> (8*b);
          mem_model[key] = line;
        end else begin
          exp_rdata_o = model_rdata(rd, sz, off);
        end
      end
      checks++; if (rdata_o !== exp_rdata_o) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, rdata_o, exp_rdata_o); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_byte();
    test_load_wait();
    test_load_store_hold();
    test_misalign();
    test_reset_midtransfer();
    test_start_ignored();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Byte-lane memory port between the datapath and a 64-bit doubleword-wide memory. It latches a load, store or fetch request from the control FSM (`addr`, `store_value`, access size), runs a valid/ready handshake toward memory with aligned address, byte enables and shifted write data, and returns LSB-aligned read data. The returned data feeds the datapath `mem_i` input, so `mem_extension` and the instruction register always see the addressed bytes starting at bit 0.

## Interface
- `AddrSize`, 64, width of request and memory addresses
- `clk` input 1, rising-edge clock
- `reset` input 1, asynchronous, active-high; clears FSM and all registered outputs
- `start` input 1, request strobe, sampled only in IDLE
- `write` input 1, 1 = store, 0 = load/fetch; sampled with `start`
- `size` input 2, 0 = byte, 1 = half, 2 = word, 3 = doubleword (func3[1:0])
- `addr` input AddrSize, byte address
- `store_value` input 64, store data, LSB-aligned
- `rdata_o` output 64, LSB-aligned read data, upper bytes zero
- `done` output 1, one-cycle completion pulse
- `busy` output 1, high in every state except IDLE
- `misaligned` output 1, error flag qualified by `done`
- `mem_valid` output 1, request valid toward memory
- `mem_we` output 1, write enable
- `mem_addr` output AddrSize, `{addr[AddrSize-1:3], 3'b000}`
- `mem_be` output 8, byte enables
- `mem_wdata` output 64, lane-shifted store data
- `mem_ready` input 1, memory accepts and completes the request this cycle
- `mem_rdata` input 64, read doubleword, valid in the `mem_ready` cycle

## Operation
- States: IDLE, REQ, RESP.
- IDLE: when `start` is 1, register `write`, `size`, `addr[2:0]`, `mem_addr`, `mem_be` and `mem_wdata`, then go to REQ. If `start` is 0, stay in IDLE.
- REQ: `mem_valid`=1 and all `mem_*` outputs held stable. When `mem_ready` is 1, capture `mem_rdata >> (8*addr[2:0])` into `rdata_o` (loads only) and go to RESP. Otherwise stay in REQ.
- RESP: `done`=1, then return to IDLE.
- Byte enables, `off = addr[2:0]`:
  - size 0: `8'h01 << off`
  - size 1: `8'h03 << off`
  - size 2: `8'h0F << off`
  - size 3: `8'hFF << off`
  - All shifts truncate to 8 bits.
- `mem_wdata = store_value << (8*off)`, truncated to 64 bits.
- `rdata_o` holds its value through stores and errors and changes only on a completed load.
- `start` while `busy` is ignored; no queueing.
- Reset mid-transfer: `mem_valid` drops asynchronously and the FSM returns to IDLE. No `done` is produced. The memory must tolerate an abandoned request.

## Timing
- Reset values: `rdata_o`=0, `done`=0, `busy`=0, `misaligned`=0, `mem_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
- All outputs are registered; there is no combinational path from `mem_ready` or `mem_rdata` to any output.
- Latency with `mem_ready` already high: `start` at edge N, `mem_valid` high in cycle N+1, `done` high in cycle N+2. Minimum 3 cycles from strike to next accepted `start`.
- Each wait cycle of `mem_ready`=0 adds exactly one cycle.
- `mem_ready` while `mem_valid`=0 is ignored.

## Configuration
- `DATA_MEM_MISALIGN_TRAP_EN` defined:
  - In IDLE with `start`, if `off` is not a multiple of 2^size, skip REQ and go directly to RESP.
  - `done`=1 and `misaligned`=1 for that cycle; `mem_valid` stays 0.
  - `rdata_o` is unchanged.
- Undefined:
  - No check is made; `misaligned` is tied to 0.
  - Bytes beyond the doubleword boundary are dropped by the enable and data truncation.

## Structure
- Package `mem_port_pkg`:
  - state enum (IDLE/REQ/RESP)
  - size constants `SIZE_B`, `SIZE_H`, `SIZE_W`, `SIZE_D`
  - `BE_WIDTH` = 8
- Sub-module `lane_align`: combinational logic taking `size`, `off`, `store_value` and producing `mem_be` and `mem_wdata`. It also provides the read right-shift and the misalignment predicate. The top level keeps only the FSM and registers.

## Test plan
- Store byte at `addr`=0x1003, `store_value`=0xAB, `mem_ready`=1 -> `mem_addr`=0x1000, `mem_be`=0x08, `mem_wdata`=0x00000000AB000000, `done` 2 cycles after `start`.
- Load word at `addr`=0x2004, `mem_rdata`=0x11223344_55667788, `mem_ready` delayed 3 cycles -> `mem_valid` held 4 cycles, `rdata_o`=0x11223344, `done` 5 cycles after `start`.
- Load doubleword at 0x0, then store -> `rdata_o` keeps the loaded value through the store.
- With the macro defined, half-word at `addr`=0x1 -> `done`=1, `misaligned`=1, `mem_valid` never asserted. Without the macro -> `mem_be`=0x06, `misaligned`=0.
- Assert `reset` during REQ with `mem_ready`=0 -> `mem_valid`=0 immediately, `busy`=0, no `done`. The next `start` completes normally.
- Pulse `start` in REQ and RESP -> ignored; exactly one `done` per accepted request.
